pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage of the MIPS datapath. Holds the fetch PC and selects the next PC from sequential, branch, jump-immediate, jump-register, exception, and exception-return sources. Adds a pipeline stall, an EPC register for `eret`, and a circular return-address stack (RAS) for one-cycle returns without a register-file read. Sits between the decode/control logic and instruction memory.

## Interface
- `ADDR_W`, 32: PC width; legal range 30..32.
- `RESET_VEC`, 32'h0000_3000: PC value after reset; truncated to `ADDR_W`.
- `EXC_VEC`, 32'hBFC0_0380: exception handler entry; truncated to `ADDR_W`.
- `RAS_DEPTH`, 4: RAS entries; power of two, 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold PC, EPC and RAS.
- `take_exception`  in  1  redirect to `EXC_VEC` and save `exc_pc` into EPC.
- `exc_pc`  in  ADDR_W  address of the faulting instruction.
- `take_eret`  in  1  redirect to EPC.
- `take_branch`  in  1  PC-relative branch.
- `branch_imm_ex`  in  ADDR_W  sign-extended word offset.
- `take_jump_imm`  in  1  absolute jump (`j`/`jal`).
- `jump_imm`  in  26  jump index field.
- `link`  in  1  with `take_jump_imm`, push `pc4` onto the RAS (`jal`).
- `take_jump_reg`  in  1  jump to `jump_reg`.
- `take_ret`  in  1  with `take_jump_reg`, predicted return (`jr $ra`).
- `jump_reg`  in  ADDR_W  register jump target.
- `pc`  out  ADDR_W  current fetch address (registered).
- `pc4`  out  ADDR_W  `pc + 4` (combinational).
- `epc`  out  ADDR_W  saved exception PC (registered).
- `ras_count`  out  5  valid RAS entries, 0..`RAS_DEPTH`.

## Operation
- **Priority on each edge, highest first:** rst > take_exception > take_eret > stall > take_branch > take_jump_imm > take_jump_reg > sequential.
- **rst:** pc <= RESET_VEC; epc <= 0; ras_count <= 0; RAS pointer <= 0. RAS contents are don't-care.
- **take_exception:** pc <= EXC_VEC; epc <= exc_pc. The RAS is unchanged. This overrides stall.
- **take_eret:** pc <= epc. The RAS is unchanged. This overrides stall.
- **stall (no exception or eret):** pc, epc and the RAS all hold.
- **take_branch:** pc <= pc4 + (branch_imm_ex << 2), modulo 2^ADDR_W.
- **take_jump_imm:** pc <= {pc4[ADDR_W-1:28], jump_imm, 2'b00}.
  - If `link` is set, push pc4.
- **take_jump_reg:**
  - If take_ret=1 and ras_count>0: pc <= RAS top; pop.
  - Otherwise: pc <= jump_reg. A pop with ras_count=0 has no effect.
- **No control input active:** pc <= pc4.
- **RAS push:**
  - Write to entry ptr; ptr <= ptr+1 mod RAS_DEPTH.
  - ras_count <= min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten.
- **RAS pop:** ptr <= ptr-1 mod RAS_DEPTH; count <= count-1. The top entry is entry ptr-1.
- **Gating:** `link` without `take_jump_imm` and `take_ret` without `take_jump_reg` are ignored. A lower-priority source never pushes or pops the RAS.

## Timing
- All registered outputs change only on the rising edge of `clk`; `pc4` follows `pc` combinationally.
- The redirect latency is 1 cycle: a control input sampled at edge N makes `pc` show the target after edge N.
- The RAS write and read are visible to the next cycle's `take_ret`. A push followed by a pop on the next edge returns the pushed value.
- A reset asserted mid-stall or mid-redirect takes effect at that edge, regardless of other inputs.
- Wrap-around: sequential increment and branch arithmetic wrap modulo 2^ADDR_W with no flag.

## Test plan
- **Reset:** hold rst for 2 cycles, then release with no controls asserted.
  - Required: pc=0x3000, epc=0, ras_count=0, then 0x3004, 0x3008 on following edges.
- **Branch and jump:** from pc=0x3000, take_branch with imm=0xFFFF_FFFF -> pc=0x3000. At pc=0x3010, take_jump_imm with imm=0x0000400 -> pc=0x0000_1000.
- **Exception / eret under stall:** with stall=1, take_exception with exc_pc=0x3020 -> pc=0xBFC0_0380 and epc=0x3020. Then take_eret -> pc=0x3020.
- **RAS basic:** at pc=0x3000, jal with link to 0x4000 -> count=1. Next, take_jump_reg with take_ret and jump_reg=0xDEAD_0000 -> pc=0x3004, count=0.
- **RAS overflow:** with RAS_DEPTH=4, do 5 links from pc4 values A..E -> count=4. Four returns yield E, D, C, B. A fifth return uses jump_reg.
- **Stall and conflicts:**
  - stall together with take_branch and link -> pc, epc and count unchanged.
  - take_branch together with take_jump_imm -> branch target taken and no push.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter for the MIPS datapath.
// Holds the fetch PC and an EPC for eret, and keeps a small circular
// return-address stack so that `jr $ra` can redirect in one cycle
// without waiting on the register file.
module pc_gen #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              take_exception,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              take_eret,
    input  logic              take_branch,
    input  logic [ADDR_W-1:0] branch_imm_ex,
    input  logic              take_jump_imm,
    input  logic [25:0]       jump_imm,
    input  logic              link,
    input  logic              take_jump_reg,
    input  logic              take_ret,
    input  logic [ADDR_W-1:0] jump_reg,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [ADDR_W-1:0] epc,
    output logic [4:0]        ras_count
);

    localparam int                PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VEC[ADDR_W-1:0];
    localparam logic [4:0]        RAS_FULL = 5'(RAS_DEPTH);

    // Parameter sanity: the jump-immediate concatenation needs ADDR_W >= 30,
    // and the pointer wrap relies on a power-of-two depth.
    generate
        if (ADDR_W < 30 || ADDR_W > 32) begin : g_bad_addr_w
            $error("pc_gen: ADDR_W must be in 30..32");
        end
        if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pc_gen: RAS_DEPTH must be a power of two in 2..16");
        end
    endgenerate

    // Next-PC source, one per priority level.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_EXC,
        SEL_ERET,
        SEL_BRANCH,
        SEL_JIMM,
        SEL_JREG,
        SEL_RET,
        SEL_SEQ
    } sel_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [4:0]        count_q, count_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    sel_e              sel;
    logic              ras_push;
    logic              ras_pop;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jimm_tgt;

    assign pc        = pc_q;
    assign pc4       = pc_q + ADDR_W'(4);
    assign epc       = epc_q;
    assign ras_count = count_q;

    // The top-of-stack entry sits one below the write pointer (wraps naturally).
    assign top_idx = ptr_q - PTR_W'(1);
    assign ras_top = ras_q[top_idx];

    // Redirect targets; all arithmetic wraps at ADDR_W bits.
    always_comb begin
        branch_tgt = pc4 + (branch_imm_ex << 2);
        jimm_tgt   = {pc4[ADDR_W-1:28], jump_imm, 2'b00};
    end

    // Priority decode of the control inputs into a single source select.
    // A predicted return with an empty stack degrades to a plain jr.
    always_comb begin
        sel = SEL_SEQ;
        if (take_exception) begin
            sel = SEL_EXC;
        end else if (take_eret) begin
            sel = SEL_ERET;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (take_branch) begin
            sel = SEL_BRANCH;
        end else if (take_jump_imm) begin
            sel = SEL_JIMM;
        end else if (take_jump_reg) begin
            sel = (take_ret && count_q != 5'd0) ? SEL_RET : SEL_JREG;
        end
    end

    // Only the winning source may touch the RAS, so link/take_ret are
    // qualified by the decoded select rather than by their raw inputs.
    always_comb begin
        ras_push = (sel == SEL_JIMM) && link;
        ras_pop  = (sel == SEL_RET);
    end

    // Next-state for PC, EPC and the RAS bookkeeping.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (sel)
            SEL_EXC: begin
                pc_d  = EXC_PC;
                epc_d = exc_pc;
            end
            SEL_ERET:   pc_d = epc_q;
            SEL_HOLD:   pc_d = pc_q;
            SEL_BRANCH: pc_d = branch_tgt;
            SEL_JIMM:   pc_d = jimm_tgt;
            SEL_JREG:   pc_d = jump_reg;
            SEL_RET:    pc_d = ras_top;
            default:    pc_d = pc4;
        endcase
        if (ras_push) begin
            ptr_d = ptr_q + PTR_W'(1);
            // When full the pointer still advances, overwriting the oldest entry.
            count_d = (count_q == RAS_FULL) ? count_q : count_q + 5'd1;
        end else if (ras_pop) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - 5'd1;
        end
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            ptr_q   <= '0;
            count_q <= 5'd0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // RAS storage: contents are don't-care after reset, so no reset term.
    // The write is gated by rst so a reset edge never leaves a stray push.
    always_ff @(posedge clk) begin
        if (!rst && ras_push) begin
            ras_q[ptr_q] <= pc4;
        end
    end

endmodule
